// File: rtl/apu_pkg.sv
// Shared APU definitions: frame-sequencer step masks, channel limits and
// the frequency-sweep arithmetic used by the square channels.
package apu_pkg;

    // Frame-sequencer steps on which each unit is clocked (bit n = step n).
    localparam logic [7:0]  LEN_STEPS   = 8'b01010101;
    localparam logic [7:0]  SWEEP_STEPS = 8'b01000100;
    localparam logic [7:0]  ENV_STEP    = 8'b10000000;

    localparam logic [10:0] MAX_FREQ    = 11'd2047;
    localparam logic [6:0]  LEN_MAX     = 7'd64;

    // A sweep period of 0 behaves like a period of 8 for the timer reload.
    localparam logic [3:0]  SWEEP_PERIOD_ZERO_RELOAD = 4'd8;

    // One-cycle clock-enable pulses produced by the frame sequencer.
    typedef struct packed {
        logic len_clk;
        logic sweep_clk;
        logic env_clk;
    } frame_clk_t;

    // New sweep frequency, kept 12 bits wide so an overflow past 2047 is visible.
    function automatic logic [11:0] sweep_calc(input logic [10:0] shadow,
                                               input logic        neg,
                                               input logic [2:0]  shift);
        logic [11:0] base;
        logic [11:0] delta;
        base  = {1'b0, shadow};
        delta = {1'b0, shadow >> shift};
        sweep_calc = neg ? (base - delta) : (base + delta);
    endfunction

    function automatic logic sweep_overflow(input logic [11:0] value);
        sweep_overflow = (value > {1'b0, MAX_FREQ});
    endfunction

endpackage

// File: rtl/apu_frame_sequencer.sv
// 512 Hz frame sequencer: a clock divider feeding a 3-bit step counter.
// Each terminal count produces one tick; the step value *before* the
// increment decides which of length / sweep / envelope is clocked.
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter int unsigned CLKS_PER_FRAME_TICK = 24000
) (
    input  logic       clk,
    input  logic       rst,
    output frame_clk_t frame_clk
);

    localparam int unsigned DIV_W = (CLKS_PER_FRAME_TICK > 1) ? $clog2(CLKS_PER_FRAME_TICK) : 1;
    localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(CLKS_PER_FRAME_TICK - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       step_q, step_d;
    logic             tick;

    // Divider wrap, step advance and per-step clock pulses.
    always_comb begin
        tick   = (div_q == DIV_TERM);
        div_d  = tick ? '0 : div_q + 1'b1;
        step_d = tick ? step_q + 3'd1 : step_q;
        frame_clk.len_clk   = tick & LEN_STEPS[step_q];
        frame_clk.sweep_clk = tick & SWEEP_STEPS[step_q];
        frame_clk.env_clk   = tick & ENV_STEP[step_q];
    end

    // Divider and step registers; reset returns to step 0 with no pending tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            step_q <= '0;
        end else begin
            div_q  <= div_d;
            step_q <= step_d;
        end
    end

endmodule

// File: rtl/square_channel_ctrl.sv
// Square-channel control stage: length counter, volume envelope and
// frequency sweep driving the square-wave generator inputs. All outputs
// are registered; a trigger shows up on the outputs the cycle after it.
module square_channel_ctrl
    import apu_pkg::*;
#(
    parameter int unsigned CLKS_PER_FRAME_TICK = 24000
) (
    input  logic        I_BITCLK,
    input  logic        I_RESET,
    input  logic        I_TRIGGER,
    input  logic        I_LENGTH_LOAD,
    input  logic [5:0]  I_LENGTH_DATA,
    input  logic        I_LENGTH_EN,
    input  logic        I_FREQ_WR,
    input  logic [10:0] I_FREQUENCY,
    input  logic [1:0]  I_DUTY,
    input  logic [3:0]  I_ENV_INIT,
    input  logic        I_ENV_DIR,
    input  logic [2:0]  I_ENV_PERIOD,
    input  logic [2:0]  I_SWEEP_PERIOD,
    input  logic        I_SWEEP_NEG,
    input  logic [2:0]  I_SWEEP_SHIFT,
    output logic [10:0] O_FREQUENCY,
    output logic [1:0]  O_DUTY_CYCLE,
    output logic [3:0]  O_VOLUME,
    output logic        O_WAVEFORM_EN
);

    frame_clk_t frame_clk;

    apu_frame_sequencer #(
        .CLKS_PER_FRAME_TICK(CLKS_PER_FRAME_TICK)
    ) u_frame_seq (
        .clk       (I_BITCLK),
        .rst       (I_RESET),
        .frame_clk (frame_clk)
    );

    logic [10:0] freq_q, freq_d;
    logic [1:0]  duty_q, duty_d;
    logic [3:0]  vol_q, vol_d;
    logic        en_q, en_d;
    logic [6:0]  length_q, length_d;
    logic [2:0]  env_timer_q, env_timer_d;
    logic [3:0]  sweep_timer_q, sweep_timer_d;
    logic        sweep_en_q, sweep_en_d;
    logic [10:0] shadow_q, shadow_d;

    logic [11:0] trig_calc;
    logic [11:0] sweep_new;
    logic [11:0] sweep_recheck;
    logic [3:0]  sweep_reload;
    logic [6:0]  length_loaded;
    logic        dac_off;

    // Sweep arithmetic, reload values and DAC state shared by the update logic.
    always_comb begin
        trig_calc     = sweep_calc(I_FREQUENCY, I_SWEEP_NEG, I_SWEEP_SHIFT);
        sweep_new     = sweep_calc(shadow_q, I_SWEEP_NEG, I_SWEEP_SHIFT);
        sweep_recheck = sweep_calc(sweep_new[10:0], I_SWEEP_NEG, I_SWEEP_SHIFT);
        sweep_reload  = (I_SWEEP_PERIOD == 3'd0) ? SWEEP_PERIOD_ZERO_RELOAD
                                                 : {1'b0, I_SWEEP_PERIOD};
        length_loaded = LEN_MAX - {1'b0, I_LENGTH_DATA};
        dac_off       = (I_ENV_INIT == 4'd0) && !I_ENV_DIR;
    end

    // Next-state for the channel: trigger wins over frame-sequencer actions,
    // a direct frequency write overrides a sweep write, DAC-off forces disable.
    always_comb begin
        freq_d        = freq_q;
        duty_d        = I_DUTY;
        vol_d         = vol_q;
        en_d          = en_q;
        length_d      = length_q;
        env_timer_d   = env_timer_q;
        sweep_timer_d = sweep_timer_q;
        sweep_en_d    = sweep_en_q;
        shadow_d      = shadow_q;

        if (I_TRIGGER) begin
            en_d = 1'b1;
            if (I_LENGTH_LOAD) begin
                length_d = length_loaded;
            end else if (length_q == 7'd0) begin
                length_d = LEN_MAX;
            end
            vol_d         = I_ENV_INIT;
            env_timer_d   = I_ENV_PERIOD;
            shadow_d      = I_FREQUENCY;
            freq_d        = I_FREQUENCY;
            sweep_timer_d = sweep_reload;
            sweep_en_d    = (I_SWEEP_PERIOD != 3'd0) || (I_SWEEP_SHIFT != 3'd0);
            if ((I_SWEEP_SHIFT != 3'd0) && sweep_overflow(trig_calc)) begin
                en_d = 1'b0;
            end
        end else begin
            // Length counter
            if (frame_clk.len_clk && I_LENGTH_EN && (length_q != 7'd0)) begin
                length_d = length_q - 7'd1;
                if (length_q == 7'd1) begin
                    en_d = 1'b0;
                end
            end
            if (I_LENGTH_LOAD) begin
                length_d = length_loaded;
            end

            // Volume envelope; a stale timer of 0 counts as expiring.
            if (frame_clk.env_clk && (I_ENV_PERIOD != 3'd0)) begin
                if (env_timer_q <= 3'd1) begin
                    env_timer_d = I_ENV_PERIOD;
                    if (I_ENV_DIR) begin
                        if (vol_q != 4'd15) vol_d = vol_q + 4'd1;
                    end else begin
                        if (vol_q != 4'd0) vol_d = vol_q - 4'd1;
                    end
                end else begin
                    env_timer_d = env_timer_q - 3'd1;
                end
            end

            // Frequency sweep
            if (frame_clk.sweep_clk) begin
                if (sweep_timer_q <= 4'd1) begin
                    sweep_timer_d = sweep_reload;
                    if (sweep_en_q && (I_SWEEP_PERIOD != 3'd0)) begin
                        if (sweep_overflow(sweep_new)) begin
                            en_d = 1'b0;
                        end else if (I_SWEEP_SHIFT != 3'd0) begin
                            shadow_d = sweep_new[10:0];
                            freq_d   = sweep_new[10:0];
                            if (sweep_overflow(sweep_recheck)) begin
                                en_d = 1'b0;
                            end
                        end
                    end
                end else begin
                    sweep_timer_d = sweep_timer_q - 4'd1;
                end
            end

            if (I_FREQ_WR) begin
                freq_d = I_FREQUENCY;
            end
        end

        if (dac_off) begin
            en_d = 1'b0;
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge I_BITCLK) begin
        if (I_RESET) begin
            freq_q        <= '0;
            duty_q        <= '0;
            vol_q         <= '0;
            en_q          <= 1'b0;
            length_q      <= '0;
            env_timer_q   <= '0;
            sweep_timer_q <= '0;
            sweep_en_q    <= 1'b0;
            shadow_q      <= '0;
        end else begin
            freq_q        <= freq_d;
            duty_q        <= duty_d;
            vol_q         <= vol_d;
            en_q          <= en_d;
            length_q      <= length_d;
            env_timer_q   <= env_timer_d;
            sweep_timer_q <= sweep_timer_d;
            sweep_en_q    <= sweep_en_d;
            shadow_q      <= shadow_d;
        end
    end

    assign O_FREQUENCY   = freq_q;
    assign O_DUTY_CYCLE  = duty_q;
    assign O_VOLUME      = vol_q;
    assign O_WAVEFORM_EN = en_q;

endmodule

// File: tb/tb_square_channel_ctrl.sv
// Bench for square_channel_ctrl with a shortened frame tick. A cycle-level
// behavioural model of the channel predicts every output vector.
module tb_square_channel_ctrl;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic        len_load = 1'b0;
    logic [5:0]  len_data = '0;
    logic        len_en = 1'b0;
    logic        freq_wr = 1'b0;
    logic [10:0] freq = '0;
    logic [1:0]  duty = '0;
    logic [3:0]  env_init = '0;
    logic        env_dir = 1'b0;
    logic [2:0]  env_period = '0;
    logic [2:0]  sw_period = '0;
    logic        sw_neg = 1'b0;
    logic [2:0]  sw_shift = '0;

    logic [10:0] o_freq;
    logic [1:0]  o_duty;
    logic [3:0]  o_vol;
    logic        o_en;

    square_channel_ctrl #(.CLKS_PER_FRAME_TICK(N)) dut (
        .I_BITCLK       (clk),
        .I_RESET        (rst),
        .I_TRIGGER      (trig),
        .I_LENGTH_LOAD  (len_load),
        .I_LENGTH_DATA  (len_data),
        .I_LENGTH_EN    (len_en),
        .I_FREQ_WR      (freq_wr),
        .I_FREQUENCY    (freq),
        .I_DUTY         (duty),
        .I_ENV_INIT     (env_init),
        .I_ENV_DIR      (env_dir),
        .I_ENV_PERIOD   (env_period),
        .I_SWEEP_PERIOD (sw_period),
        .I_SWEEP_NEG    (sw_neg),
        .I_SWEEP_SHIFT  (sw_shift),
        .O_FREQUENCY    (o_freq),
        .O_DUTY_CYCLE   (o_duty),
        .O_VOLUME       (o_vol),
        .O_WAVEFORM_EN  (o_en)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [17:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame timing from the cycle count since reset: tick on the last cycle
    // of every N, step = number of completed ticks modulo 8.
    int m_cyc, m_freq, m_duty, m_vol, m_en, m_len, m_envt, m_swt, m_swen, m_shadow;

    function automatic int swp(input int sh, input int neg, input int shift);
        return neg ? sh - (sh >> shift) : sh + (sh >> shift);
    endfunction

    task automatic model_step();
        int step;
        bit tick;
        int reload;
        int nw;
        if (rst) begin
            m_cyc = 0; m_freq = 0; m_duty = 0; m_vol = 0; m_en = 0;
            m_len = 0; m_envt = 0; m_swt = 0; m_swen = 0; m_shadow = 0;
            return;
        end
        tick = ((m_cyc % N) == N - 1);
        step = (m_cyc / N) % 8;
        m_cyc++;
        m_duty = duty;
        reload = (sw_period == 0) ? 8 : int'(sw_period);
        if (trig) begin
            m_en = 1;
            if (len_load) m_len = 64 - int'(len_data);
            else if (m_len == 0) m_len = 64;
            m_vol = env_init;
            m_envt = env_period;
            m_shadow = freq;
            m_freq = freq;
            m_swt = reload;
            m_swen = (sw_period != 0 || sw_shift != 0) ? 1 : 0;
            if (sw_shift != 0 && swp(int'(freq), int'(sw_neg), int'(sw_shift)) > 2047) m_en = 0;
        end else begin
            if (tick && (step % 2 == 0) && len_en && m_len != 0) begin
                m_len = m_len - 1;
                if (m_len == 0) m_en = 0;
            end
            if (len_load) m_len = 64 - int'(len_data);
            if (tick && step == 7 && env_period != 0) begin
                if (m_envt <= 1) begin
                    m_envt = env_period;
                    if (env_dir) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
                    else         m_vol = (m_vol > 0) ? m_vol - 1 : 0;
                end else begin
                    m_envt = m_envt - 1;
                end
            end
            if (tick && (step == 2 || step == 6)) begin
                if (m_swt <= 1) begin
                    m_swt = reload;
                    if (m_swen && sw_period != 0) begin
                        nw = swp(m_shadow, int'(sw_neg), int'(sw_shift));
                        if (nw > 2047) m_en = 0;
                        else if (sw_shift != 0) begin
                            m_shadow = nw;
                            m_freq = nw;
                            if (swp(nw, int'(sw_neg), int'(sw_shift)) > 2047) m_en = 0;
                        end
                    end
                end else begin
                    m_swt = m_swt - 1;
                end
            end
            if (freq_wr) m_freq = freq;
        end
        if (env_init == 0 && env_dir == 0) m_en = 0;
    endtask

    // ---------------- driver ----------------
    // One clock: predict, clock the DUT, compare, then drop one-cycle pulses.
    task automatic cycle();
        logic [17:0] e;
        model_step();
        exp_q.push_back({11'(m_freq), 2'(m_duty), 4'(m_vol), 1'(m_en)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("outputs@%0t", $time), {14'd0, o_freq, o_duty, o_vol, o_en}, {14'd0, e});
        trig = 1'b0;
        len_load = 1'b0;
        freq_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        // Reset state
        duty = 2'd2;
        do_reset();
        check("reset_step", 32'(dut.u_frame_seq.step_q), 32'd0);
        check("reset_en", 32'(o_en), 32'd0);

        // Length: load 62 (length 2), expire on the step-2 length clock
        env_init = 4'd15; env_dir = 1'b0; len_en = 1'b1;
        do_reset();
        len_load = 1'b1; len_data = 6'd62;
        cycle();
        trig = 1'b1;
        cycle();
        check("len_trig_en", 32'(o_en), 32'd1);
        for (int i = 0; i < 200 && o_en; i++) cycle();
        check("len_expired_en", 32'(o_en), 32'd0);
        check("len_expired_step", 32'(dut.u_frame_seq.step_q), 32'd3);

        // Envelope: 3 rising to 15 then holding
        len_en = 1'b0; env_init = 4'd3; env_dir = 1'b1; env_period = 3'd1;
        do_reset();
        trig = 1'b1;
        cycle();
        check("env_start", 32'(o_vol), 32'd3);
        for (int i = 0; i < 30; i++) cycle();
        check("env_before_step7", 32'(o_vol), 32'd3);
        cycle();
        check("env_first_step", 32'(o_vol), 32'd4);
        for (int i = 0; i < 12 * 8 * N; i++) cycle();
        check("env_saturated", 32'(o_vol), 32'd15);

        // Sweep: 1024 -> 1536, then the recheck (2304) disables
        env_init = 4'd15; env_dir = 1'b0; env_period = 3'd0;
        freq = 11'd1024; sw_period = 3'd1; sw_neg = 1'b0; sw_shift = 3'd1;
        do_reset();
        trig = 1'b1;
        cycle();
        check("sweep_trig_en", 32'(o_en), 32'd1);
        for (int i = 0; i < 100 && o_en; i++) cycle();
        check("sweep_freq", 32'(o_freq), 32'd1536);
        check("sweep_disabled", 32'(o_en), 32'd0);
        check("sweep_step", 32'(dut.u_frame_seq.step_q), 32'd3);

        // Immediate overflow on trigger
        freq = 11'd2000; sw_period = 3'd0; sw_shift = 3'd1;
        trig = 1'b1;
        cycle();
        check("imm_ovf_en", 32'(o_en), 32'd0);
        check("imm_ovf_freq", 32'(o_freq), 32'd2000);

        // DAC off blocks trigger; DAC on re-enables
        sw_shift = 3'd0; freq = 11'd300;
        env_init = 4'd0; env_dir = 1'b0;
        trig = 1'b1;
        cycle();
        check("dac_off_en", 32'(o_en), 32'd0);
        env_init = 4'd5;
        trig = 1'b1;
        cycle();
        check("dac_on_en", 32'(o_en), 32'd1);
        check("dac_on_vol", 32'(o_vol), 32'd5);

        // Reset coincident with trigger on a running channel
        for (int i = 0; i < 7; i++) cycle();
        rst = 1'b1; trig = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_trig_outs", {14'd0, o_freq, o_duty, o_vol, o_en}, 32'd0);
        check("rst_trig_step", 32'(dut.u_frame_seq.step_q), 32'd0);
        cycle();
        check("rst_idle_div", 32'(dut.u_frame_seq.div_q), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if (i % 40 == 0) begin
                freq       = 11'($urandom_range(0, 2047));
                env_init   = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                env_dir    = 1'($urandom_range(0, 1));
                env_period = 3'($urandom_range(0, 7));
                sw_period  = 3'($urandom_range(0, 7));
                sw_neg     = 1'($urandom_range(0, 1));
                sw_shift   = 3'($urandom_range(0, 7));
                len_en     = 1'($urandom_range(0, 1));
            end
            duty     = 2'($urandom_range(0, 3));
            rst      = ($urandom_range(0, 299) == 0);
            trig     = ($urandom_range(0, 49) == 0);
            len_load = ($urandom_range(0, 29) == 0);
            len_data = 6'($urandom_range(0, 63));
            freq_wr  = ($urandom_range(0, 29) == 0);
            if (freq_wr) freq = 11'($urandom_range(0, 2047));
            cycle();
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
